// File: rtl/iob_uart_rx_fc.sv
// ---------------------------------------------------------------------------
// iob_uart_rx_fc
//   8N1 UART receiver with a small receive FIFO and RTS flow control.
//
//   Receive path: rxd_i -> 2-flop synchronizer -> falling-edge start
//   detection -> mid-bit sampling FSM -> FIFO.  rts_o tells the peer to
//   stop sending while the FIFO still has headroom for in-flight bytes.
//
// Ports
//   clk_i          system clock, rising edge
//   cke_i          clock enable; when 0 all state holds
//   arst_i         asynchronous active-high reset
//   rxd_i          asynchronous serial input, idle high
//   rts_o          request-to-send (1 = peer may transmit), registered
//   data_o         byte at the FIFO head
//   valid_o        FIFO not empty
//   ready_i        consumer pops the head when valid_o & ready_i
//   frame_err_o    one-cycle pulse when a stop bit is sampled 0
//   overrun_err_o  one-cycle pulse when a byte is dropped on a full FIFO
//
// Handshake: a pop happens on a rising clk_i edge where cke_i, valid_o and
// ready_i are all 1; ready_i while valid_o = 0 has no effect.
// ---------------------------------------------------------------------------
module iob_uart_rx_fc #(
    parameter int FREQ   = 100000000,
    parameter int BAUD   = 115200,
    parameter int FIFO_W = 4
) (
    input  logic       clk_i,
    input  logic       cke_i,
    input  logic       arst_i,
    input  logic       rxd_i,
    output logic       rts_o,
    output logic [7:0] data_o,
    output logic       valid_o,
    input  logic       ready_i,
    output logic       frame_err_o,
    output logic       overrun_err_o
);

    localparam int DIV   = FREQ / BAUD;
    localparam int DEPTH = 2 ** FIFO_W;
    localparam int CNT_W = $clog2(DIV);

    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(DIV / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(DIV - 1);
    localparam logic [FIFO_W:0]  FULL_LVL  = (FIFO_W + 1)'(DEPTH);
    localparam logic [FIFO_W:0]  RTS_MAX   = (FIFO_W + 1)'(DEPTH - 3);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    // Synchronizer and edge detect
    logic rx_meta;
    logic rx;
    logic rx_d;

    // Receive FSM
    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_n;
    logic [2:0]       bit_idx;
    logic [2:0]       bit_idx_n;
    logic [7:0]       shreg;
    logic [7:0]       shreg_n;
    logic             push;
    logic             frame_ev;

    // FIFO
    logic [7:0]    mem [DEPTH];
    logic [FIFO_W:0] wptr;
    logic [FIFO_W:0] rptr;
    logic [FIFO_W:0] level;
    logic            full;
    logic            pop;
    logic            do_push;
    logic            overrun_ev;

    // -----------------------------------------------------------------------
    // Next-state logic.  The counter is loaded with N-1 on entry to a phase
    // and the sample is taken on the edge where it reads 0, so a load of
    // DIV/2-1 at cycle t samples at t+DIV/2.
    // -----------------------------------------------------------------------
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        push      = 1'b0;
        frame_ev  = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_d && !rx) begin
                    state_n = S_START;
                    cnt_n   = HALF_LOAD;
                end
            end

            S_START: begin
                if (cnt == '0) begin
                    if (rx) begin
                        // Low pulse shorter than half a bit: treat as glitch.
                        state_n = S_IDLE;
                    end else begin
                        state_n   = S_DATA;
                        cnt_n     = BIT_LOAD;
                        bit_idx_n = 3'd0;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            S_DATA: begin
                if (cnt == '0) begin
                    // LSB arrives first, so shift in from the top.
                    shreg_n = {rx, shreg[7:1]};
                    cnt_n   = BIT_LOAD;
                    if (bit_idx == 3'd7) begin
                        state_n = S_STOP;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            S_STOP: begin
                if (cnt == '0) begin
                    if (rx) begin
                        push    = 1'b1;
                        state_n = S_IDLE;
                    end else begin
                        frame_ev = 1'b1;
                        state_n  = S_BREAK;
                    end
                end else begin
                    cnt_n = cnt - 1'b1;
                end
            end

            S_BREAK: begin
                // A held-low line must return high before a new start counts.
                if (rx) begin
                    state_n = S_IDLE;
                end
            end

            default: begin
                state_n = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FIFO control.  A same-cycle pop frees the slot the push needs, so a
    // full FIFO only overruns when nothing is popped.
    // -----------------------------------------------------------------------
    assign level      = wptr - rptr;
    assign full       = (level == FULL_LVL);
    assign valid_o    = (wptr != rptr);
    assign pop        = valid_o & ready_i;
    assign do_push    = push & (~full | pop);
    assign overrun_ev = push & full & ~pop;
    assign data_o     = mem[rptr[FIFO_W-1:0]];

    // -----------------------------------------------------------------------
    // Sequential state
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            rx_meta       <= 1'b1;
            rx            <= 1'b1;
            rx_d          <= 1'b1;
            state         <= S_IDLE;
            cnt           <= '0;
            bit_idx       <= 3'd0;
            shreg         <= 8'd0;
            wptr          <= '0;
            rptr          <= '0;
            rts_o         <= 1'b0;
            frame_err_o   <= 1'b0;
            overrun_err_o <= 1'b0;
        end else if (cke_i) begin
            rx_meta       <= rxd_i;
            rx            <= rx_meta;
            rx_d          <= rx;
            state         <= state_n;
            cnt           <= cnt_n;
            bit_idx       <= bit_idx_n;
            shreg         <= shreg_n;
            if (do_push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            rts_o         <= (level <= RTS_MAX);
            frame_err_o   <= frame_ev;
            overrun_err_o <= overrun_ev;
        end
    end

    // Storage is reset so data_o reads 0 out of reset.
    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= 8'd0;
            end
        end else if (cke_i && do_push) begin
            mem[wptr[FIFO_W-1:0]] <= shreg;
        end
    end

endmodule

// File: tb/tb_iob_uart_rx_fc.sv
// ---------------------------------------------------------------------------
// tb_iob_uart_rx_fc
//   Bench for iob_uart_rx_fc with DIV = 16 and a 4-entry FIFO.  Frames are
//   driven bit-serially; a queue holds the bytes the receiver should be
//   storing and counters hold the error pulses it should have produced.
// ---------------------------------------------------------------------------
module tb_iob_uart_rx_fc;

  localparam int FREQ   = 1600;
  localparam int BAUD   = 100;
  localparam int FIFO_W = 2;
  localparam int DEPTH  = 4;
  localparam int DIV    = 16;

  logic       clk = 1'b0;
  logic       cke = 1'b1;
  logic       arst = 1'b1;
  logic       rxd = 1'b1;
  logic       ready = 1'b0;
  logic       rts_o;
  logic [7:0] data_o;
  logic       valid_o;
  logic       frame_err_o;
  logic       overrun_err_o;

  iob_uart_rx_fc #(
    .FREQ  (FREQ),
    .BAUD  (BAUD),
    .FIFO_W(FIFO_W)
  ) dut (
    .clk_i        (clk),
    .cke_i        (cke),
    .arst_i       (arst),
    .rxd_i        (rxd),
    .rts_o        (rts_o),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready),
    .frame_err_o  (frame_err_o),
    .overrun_err_o(overrun_err_o)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_errors = 0;
  int fe_seen = 0;
  int ov_seen = 0;
  int fe_exp = 0;
  int ov_exp = 0;
  logic [7:0] exp_q[$];

  // Every high cycle of a pulse output is counted, so a stretched pulse shows.
  always @(negedge clk) begin
    if (frame_err_o) fe_seen++;
    if (overrun_err_o) ov_seen++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_flags();
    check("frame_err_count", fe_seen, fe_exp);
    check("overrun_count", ov_seen, ov_exp);
    check("rts", rts_o, exp_q.size() <= DEPTH - 3);
    check("valid", valid_o, exp_q.size() > 0);
    if (exp_q.size() > 0) check("head", data_o, exp_q[0]);
  endtask

  task automatic check_reset_outputs();
    check("rst_data", data_o, 0);
    check("rst_valid", valid_o, 0);
    check("rst_rts", rts_o, 0);
    check("rst_frame_err", frame_err_o, 0);
    check("rst_overrun", overrun_err_o, 0);
  endtask

  // One 8N1 frame, one bit per 16 cycles.  With rxd changed on negedge i,
  // the synchronized start is seen on posedge 3, so the stop bit is sampled
  // on posedge 155 -- the edge right after the negedge of iteration 154.
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input bit pop_at_stop);
    logic [9:0] bits;
    bits = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      rxd = bits[i / DIV];
      if (i == 154) begin
        if (stop_bit) check("valid_before_push", valid_o, exp_q.size() > 0);
        if (pop_at_stop && exp_q.size() > 0) begin
          check("pop_at_stop_data", data_o, exp_q.pop_front());
          ready = 1'b1;
        end
      end
      if (i == 155) begin
        ready = 1'b0;
        if (stop_bit) begin
          if (exp_q.size() < DEPTH) exp_q.push_back(b);
          else ov_exp++;
          check("valid_after_push", valid_o, exp_q.size() > 0);
          check("head_after_push", data_o, exp_q[0]);
        end else begin
          fe_exp++;
        end
      end
    end
  endtask

  task automatic pop_one();
    @(negedge clk);
    check("pop_valid", valid_o, 1);
    check("pop_data", data_o, exp_q.pop_front());
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
  endtask

  task automatic drain();
    while (exp_q.size() > 0) pop_one();
    idle(2);
    check("drained_valid", valid_o, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] bits;
    logic [7:0] b;
    logic       stop;
    int         npop;

    // Reset and release
    idle(3);
    check_reset_outputs();
    arst = 1'b0;
    @(negedge clk);
    check("rts_after_reset", rts_o, 1);
    idle(5);

    // Single byte, no consumer
    send_frame(8'hA5, 1'b1, 1'b0);
    idle(4);
    check_flags();
    drain();

    // Short low glitch must not start a frame
    @(negedge clk);
    rxd = 1'b0;
    idle(5);
    rxd = 1'b1;
    idle(40);
    check_flags();
    send_frame(8'h5A, 1'b1, 1'b0);
    idle(4);
    check_flags();
    drain();

    // Framing error followed by a long break, then a clean byte
    send_frame(8'h3C, 1'b0, 1'b0);
    idle(100);
    rxd = 1'b1;
    idle(20);
    check_flags();
    send_frame(8'h11, 1'b1, 1'b0);
    idle(4);
    check_flags();
    drain();

    // Fill past capacity: rts drops at level 2, fifth byte overruns
    for (int k = 1; k <= 5; k++) begin
      send_frame(8'(k), 1'b1, 1'b0);
      idle(3);
      if (k == 1) check("rts_after_byte1", rts_o, 1);
      if (k == 2) check("rts_after_byte2", rts_o, 0);
      check_flags();
    end
    drain();

    // Full FIFO, pop on the stop-sample edge: push and pop both succeed
    for (int k = 0; k < DEPTH; k++) begin
      send_frame(8'($urandom_range(0, 255)), 1'b1, 1'b0);
      idle(2);
    end
    send_frame(8'h77, 1'b1, 1'b1);
    idle(3);
    check("level_full_after_swap", exp_q.size() == DEPTH && rts_o == 1'b0 && valid_o, 1);
    check_flags();
    drain();

    // Clock enable low freezes the FIFO even with ready high
    send_frame(8'hC3, 1'b1, 1'b0);
    idle(3);
    cke = 1'b0;
    ready = 1'b1;
    idle(4);
    check("cke_hold_valid", valid_o, 1);
    check("cke_hold_data", data_o, exp_q[0]);
    ready = 1'b0;
    cke = 1'b1;
    idle(2);
    check_flags();
    drain();

    // Randomized traffic with occasional framing errors and random pops
    for (int n = 0; n < 16; n++) begin
      b = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 5) != 0);
      send_frame(b, stop, 1'b0);
      if (!stop) begin
        idle($urandom_range(5, 40));
        rxd = 1'b1;
      end
      idle($urandom_range(3, 20));
      check_flags();
      npop = $urandom_range(0, 2);
      for (int p = 0; p < npop; p++) begin
        if (exp_q.size() > 0) pop_one();
      end
      idle(2);
      check_flags();
    end
    drain();

    // Reset in the middle of bit 4 of a frame; FIFO holds a byte beforehand
    send_frame(8'h42, 1'b1, 1'b0);
    idle(3);
    bits = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 10 * DIV; i++) begin
      @(negedge clk);
      rxd = bits[i / DIV];
      if (i == 84) arst = 1'b1;
      if (i == 86) begin
        check_reset_outputs();
        exp_q.delete();
      end
      if (i == 88) arst = 1'b0;
      if (i == 89) check("rts_after_midframe_reset", rts_o, 1);
    end
    idle(20);
    check_flags();
    send_frame(8'h96, 1'b1, 1'b0);
    idle(4);
    check_flags();
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
